// File: rtl/regn_pkg.sv
// Shared widths and FSM encoding for the register-file write-back controller.
package regn_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int RD_W  = $clog2(NREGS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry in-order FIFO holding {rd, data} write-back results.
module wb_fifo2 #(
    parameter int W = 37
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/regn_wb_ctrl.sv
// Write-back controller: queues results, drives one-hot register writes, and
// runs a drain-then-clear sequence that zeroes x1..x(NREGS-1).
module regn_wb_ctrl
    import regn_pkg::*;
#(
    parameter int XLEN  = regn_pkg::XLEN,
    parameter int NREGS = regn_pkg::NREGS
) (
    input  logic                     clk,
    input  logic                     reset,
    // A result transfers on every rising edge where wb_valid && wb_ready.
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [$clog2(NREGS)-1:0] wb_rd,
    input  logic [XLEN-1:0]          wb_data,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic [XLEN-1:0]          rf_din,
    output logic [NREGS-1:0]         rf_enable,
    output logic [NREGS-1:0]         rf_reset,
    output state_t                   dbg_state
);

    localparam int RDW = $clog2(NREGS);
    localparam int FW  = RDW + XLEN;
    localparam logic [NREGS-1:0] ONE      = NREGS'(1);
    localparam logic [RDW-1:0]   CNT_LAST = RDW'(NREGS - 1);
    localparam logic [RDW-1:0]   CNT_FIRST = RDW'(1);

    state_t         state;
    state_t         state_nxt;
    logic [RDW-1:0] cnt;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           pop;
    logic [FW-1:0]  head;
    logic [RDW-1:0] head_rd;
    logic [XLEN-1:0] head_data;

    wb_fifo2 #(.W(FW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({wb_rd, wb_data}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_rd   = head[FW-1 -: RDW];
    assign head_data = head[XLEN-1:0];

    assign wb_ready  = reset && (state == IDLE) && !fifo_full;
    assign push      = wb_valid && wb_ready;
    // Popping stops during CLEAR so no write can collide with a register clear.
    assign pop       = !fifo_empty && (state != CLEAR);
    assign clr_busy  = reset && (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        rf_reset = ONE;
        if (!reset) begin
            rf_reset = '1;
        end else if (state == CLEAR) begin
            rf_reset = (ONE << cnt) | ONE;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_req) state_nxt = DRAIN;
            DRAIN:   if (fifo_empty) state_nxt = CLEAR;
            CLEAR:   if (cnt == CNT_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= CNT_FIRST;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) begin
                cnt <= (cnt == CNT_LAST) ? CNT_FIRST : cnt + RDW'(1);
            end
        end
    end

    // Registered write stage; x0 is masked out of the enable so it is never written.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_enable <= '0;
            rf_din    <= '0;
        end else if (pop) begin
            rf_enable <= (ONE << head_rd) & ~ONE;
            rf_din    <= head_data;
        end else begin
            rf_enable <= '0;
        end
    end

endmodule

// File: tb/tb_regn_wb_ctrl.sv
// Directed self-checking bench for regn_wb_ctrl.
module tb_regn_wb_ctrl;
    import regn_pkg::*;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        clr_req;
    logic        clr_busy;
    logic [31:0] rf_din;
    logic [31:0] rf_enable;
    logic [31:0] rf_reset;
    state_t      dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 0;

    regn_wb_ctrl #(.XLEN(32), .NREGS(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .rf_din    (rf_din),
        .rf_enable (rf_enable),
        .rf_reset  (rf_reset),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Enable and clear must never target the same register above x0.
    always @(negedge clk) begin
        if (started && reset === 1'b1)
            check("excl", 64'(rf_enable & rf_reset & 32'hFFFF_FFFE), 64'd0);
    end

    initial begin
        reset    = 1'b0;
        wb_valid = 1'b0;
        wb_rd    = 5'd0;
        wb_data  = 32'd0;
        clr_req  = 1'b0;

        // Reset behaviour
        @(negedge clk);
        check("rst_rfreset", 64'(rf_reset), 64'hFFFF_FFFF);
        check("rst_ready",   64'(wb_ready), 64'd0);
        check("rst_busy",    64'(clr_busy), 64'd0);
        step();
        step();
        check("rst_en",  64'(rf_enable), 64'd0);
        check("rst_din", 64'(rf_din),    64'd0);
        check("rst_st",  64'(dbg_state), 64'(IDLE));
        reset = 1'b1;
        #1;
        started = 1;
        check("rel_ready",   64'(wb_ready), 64'd1);
        check("rel_rfreset", 64'(rf_reset), 64'd1);
        check("rel_busy",    64'(clr_busy), 64'd0);

        // Single write, latency and one-cycle pulse
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        step();
        wb_valid = 1'b0;
        check("w1_en_k",  64'(rf_enable), 64'd0);
        step();
        check("w1_en",  64'(rf_enable), 64'h20);
        check("w1_din", 64'(rf_din),    64'hDEAD_BEEF);
        step();
        check("w1_en_off",  64'(rf_enable), 64'd0);
        check("w1_din_hold", 64'(rf_din),   64'hDEAD_BEEF);

        // Back-to-back writes
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h11;
        step();
        check("b2b_rdy0", 64'(wb_ready), 64'd1);
        wb_rd = 5'd2; wb_data = 32'h22;
        step();
        check("b2b_en1",  64'(rf_enable), 64'h2);
        check("b2b_din1", 64'(rf_din),    64'h11);
        check("b2b_rdy1", 64'(wb_ready),  64'd1);
        wb_rd = 5'd3; wb_data = 32'h33;
        step();
        check("b2b_en2",  64'(rf_enable), 64'h4);
        check("b2b_din2", 64'(rf_din),    64'h22);
        check("b2b_rdy2", 64'(wb_ready),  64'd1);
        wb_valid = 1'b0;
        step();
        check("b2b_en3",  64'(rf_enable), 64'h8);
        check("b2b_din3", 64'(rf_din),    64'h33);
        step();
        check("b2b_en_off", 64'(rf_enable), 64'd0);

        // Write to x0
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
        step();
        wb_valid = 1'b0;
        check("x0_rst_a", 64'(rf_reset), 64'd1);
        step();
        check("x0_en",    64'(rf_enable), 64'd0);
        check("x0_din",   64'(rf_din),    64'h1234);
        check("x0_rst_b", 64'(rf_reset),  64'd1);

        // Two results with clr_req on the second; drain then full clear
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hA0A0_0007;
        step();
        wb_rd = 5'd9; wb_data = 32'hB0B0_0009; clr_req = 1'b1;
        check("dr_rdy_idle", 64'(wb_ready), 64'd1);
        step();
        clr_req = 1'b0;
        check("dr_st",    64'(dbg_state), 64'(DRAIN));
        check("dr_rdy",   64'(wb_ready),  64'd0);
        check("dr_busy",  64'(clr_busy),  64'd1);
        check("dr_en_a",  64'(rf_enable), 64'h80);
        check("dr_din_a", 64'(rf_din),    64'hA0A0_0007);
        step();
        check("dr_st2",   64'(dbg_state), 64'(DRAIN));
        check("dr_en_b",  64'(rf_enable), 64'h200);
        check("dr_din_b", 64'(rf_din),    64'hB0B0_0009);
        check("dr_rdy2",  64'(wb_ready),  64'd0);
        step();
        wb_valid = 1'b0;
        check("cl_st", 64'(dbg_state), 64'(CLEAR));
        for (int c = 1; c <= 31; c++) begin
            check($sformatf("cl_rst%0d", c), 64'(rf_reset), (64'd1 << c) | 64'd1);
            check($sformatf("cl_en%0d", c),  64'(rf_enable), 64'd0);
            check($sformatf("cl_busy%0d", c), 64'(clr_busy), 64'd1);
            step();
        end
        check("cl_end_st",   64'(dbg_state), 64'(IDLE));
        check("cl_end_busy", 64'(clr_busy),  64'd0);
        check("cl_end_rdy",  64'(wb_ready),  64'd1);
        check("cl_end_rst",  64'(rf_reset),  64'd1);

        // Second clr_req during CLEAR is ignored
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        check("ig_st_dr", 64'(dbg_state), 64'(DRAIN));
        step();
        for (int c = 1; c <= 31; c++) begin
            check($sformatf("ig_rst%0d", c), 64'(rf_reset), (64'd1 << c) | 64'd1);
            clr_req = (c == 20);
            step();
        end
        clr_req = 1'b0;
        check("ig_end_st",   64'(dbg_state), 64'(IDLE));
        check("ig_end_busy", 64'(clr_busy),  64'd0);
        step();
        check("ig_norestart_st",  64'(dbg_state), 64'(IDLE));
        check("ig_norestart_rst", 64'(rf_reset),  64'd1);

        // Reset in the middle of CLEAR
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        step();
        for (int c = 1; c <= 9; c++) step();
        check("ab_cnt10", 64'(rf_reset), 64'h401);
        reset = 1'b0;
        #1;
        check("ab_rst_comb",  64'(rf_reset), 64'hFFFF_FFFF);
        check("ab_busy_comb", 64'(clr_busy), 64'd0);
        check("ab_rdy_comb",  64'(wb_ready), 64'd0);
        step();
        check("ab_st",   64'(dbg_state), 64'(IDLE));
        check("ab_rst",  64'(rf_reset),  64'hFFFF_FFFF);
        check("ab_busy", 64'(clr_busy),  64'd0);
        check("ab_din",  64'(rf_din),    64'd0);
        reset = 1'b1;
        #1;
        check("ab_rel_rdy", 64'(wb_ready), 64'd1);
        check("ab_rel_rst", 64'(rf_reset), 64'd1);
        step();
        check("ab_rel_en", 64'(rf_enable), 64'd0);
        check("ab_rel_st", 64'(dbg_state), 64'(IDLE));

        // Reset during DRAIN discards the buffered result
        wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h4444; clr_req = 1'b1;
        step();
        wb_valid = 1'b0; clr_req = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("disc_en",  64'(rf_enable), 64'd0);
        check("disc_din", 64'(rf_din),    64'd0);
        check("disc_st",  64'(dbg_state), 64'(IDLE));

        started = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
